// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters for decode-stage hazard checks.
// Optional macro SCB_WB_BYPASS_EN lets a same-cycle final release clear the query outputs.
module reg_scoreboard #(
    parameter int NREG   = 16,
    parameter int W_NAME = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_NAME-1:0] rd_name_i,
    input  logic [W_NAME-1:0] rs_name_i,
    output logic              rd_reserved_o,
    output logic              rs_reserved_o,
    input  logic              reserve_i,
    input  logic [W_NAME-1:0] reserve_name_i,
    input  logic              release_i,
    input  logic [W_NAME-1:0] release_name_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              idle_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREG];
    logic             err_q;
    logic             same_name;
    logic             rel_ok;
    logic             res_ok;
    logic             proto_err;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             rd_fwd;
    logic             rs_fwd;

    // A full reserve is still legal when the same register is released in that cycle.
    always_comb begin
        full_o    = (cnt[reserve_name_i] == CNT_MAX);
        same_name = reserve_i && release_i && (reserve_name_i == release_name_i);
        rel_ok    = release_i && (cnt[release_name_i] != '0);
        res_ok    = reserve_i && (!full_o || (same_name && rel_ok));
        proto_err = (reserve_i && !res_ok) || (release_i && !rel_ok);
        inc_vec   = '0;
        dec_vec   = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = res_ok && (reserve_name_i == W_NAME'(i));
            dec_vec[i] = rel_ok && (release_name_i == W_NAME'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err_q <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (proto_err) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

`ifdef SCB_WB_BYPASS_EN
    // The last outstanding write retiring this cycle forwards, so the operand is no longer a hazard.
    always_comb begin
        rd_fwd = release_i && (release_name_i == rd_name_i) && (cnt[rd_name_i] == CNT_ONE);
        rs_fwd = release_i && (release_name_i == rs_name_i) && (cnt[rs_name_i] == CNT_ONE);
    end
`else
    assign rd_fwd = 1'b0;
    assign rs_fwd = 1'b0;
`endif

    always_comb begin
        rd_reserved_o = (cnt[rd_name_i] != '0) && !rd_fwd;
        rs_reserved_o = (cnt[rs_name_i] != '0) && !rs_fwd;
        idle_o        = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (cnt[i] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver pushes model predictions, monitor pops and compares.
// Model honours SCB_WB_BYPASS_EN the same way the build does.
module tb_reg_scoreboard;

    localparam int NREG   = 16;
    localparam int W_NAME = 4;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [W_NAME-1:0] rd_name_i;
    logic [W_NAME-1:0] rs_name_i;
    logic              rd_reserved_o;
    logic              rs_reserved_o;
    logic              reserve_i;
    logic [W_NAME-1:0] reserve_name_i;
    logic              release_i;
    logic [W_NAME-1:0] release_name_i;
    logic              flush_i;
    logic              full_o;
    logic              idle_o;
    logic              err_o;

    typedef struct {
        bit rd_res;
        bit rs_res;
        bit full;
        bit idle;
        bit err;
    } exp_t;

    exp_t expq[$];
    int   cnt_m[NREG];
    bit   err_m;
    bit   model_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reg_scoreboard #(.NREG(NREG), .W_NAME(W_NAME), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_name_i      (rd_name_i),
        .rs_name_i      (rs_name_i),
        .rd_reserved_o  (rd_reserved_o),
        .rs_reserved_o  (rs_reserved_o),
        .reserve_i      (reserve_i),
        .reserve_name_i (reserve_name_i),
        .release_i      (release_i),
        .release_name_i (release_name_i),
        .flush_i        (flush_i),
        .full_o         (full_o),
        .idle_o         (idle_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    function automatic bit query_exp(int q, bit rel, int reln);
        bit busy;
        busy = (cnt_m[q] > 0);
`ifdef SCB_WB_BYPASS_EN
        if (rel && reln == q && cnt_m[q] == 1) busy = 1'b0;
`endif
        return busy;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input bit expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: predict this cycle's outputs, then advance the model past the edge.
    task automatic applyStimulus(input bit r, input bit rsv, input int rsn, input bit rel,
                                 input int reln, input bit fl, input int rdq, input int rsq);
        exp_t e;
        bit   rsv_ok;
        bit   rel_ok;
        @(negedge clk);
        rst            = r;
        reserve_i      = rsv;
        reserve_name_i = W_NAME'(rsn);
        release_i      = rel;
        release_name_i = W_NAME'(reln);
        flush_i        = fl;
        rd_name_i      = W_NAME'(rdq);
        rs_name_i      = W_NAME'(rsq);
        if (model_valid) begin
            e.rd_res = query_exp(rdq, rel, reln);
            e.rs_res = query_exp(rsq, rel, reln);
            e.full   = (cnt_m[rsn] == MAXC);
            e.idle   = 1'b1;
            foreach (cnt_m[i]) if (cnt_m[i] != 0) e.idle = 1'b0;
            e.err    = err_m;
            expq.push_back(e);
        end
        if (r) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            err_m       = 1'b0;
            model_valid = 1'b1;
        end else if (fl) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
        end else begin
            rel_ok = rel && cnt_m[reln] > 0;
            rsv_ok = rsv && (cnt_m[rsn] < MAXC || (rel_ok && reln == rsn));
            if ((rsv && !rsv_ok) || (rel && !rel_ok)) err_m = 1'b1;
            if (rsv_ok) cnt_m[rsn] = cnt_m[rsn] + 1;
            if (rel_ok) cnt_m[reln] = cnt_m[reln] - 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("rd_reserved", rd_reserved_o, e.rd_res);
                checkOutput("rs_reserved", rs_reserved_o, e.rs_res);
                checkOutput("full", full_o, e.full);
                checkOutput("idle", idle_o, e.idle);
                checkOutput("err", err_o, e.err);
            end
        end
    end

    initial begin : driver
        int rsn, reln, rdq, rsq;
        bit rsv, rel, fl, r;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
        // reserve r3, query it, release it
        applyStimulus(0, 1, 3, 0, 0, 0, 3, 3);
        applyStimulus(0, 0, 0, 1, 3, 0, 3, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
        // saturate r5 and overflow it
        repeat (3) applyStimulus(0, 1, 5, 0, 0, 0, 5, 5);
        applyStimulus(0, 1, 5, 0, 0, 0, 5, 5);
        applyStimulus(0, 0, 5, 0, 0, 0, 5, 0);
        applyStimulus(0, 0, 5, 0, 0, 0, 5, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        // full r7 with same-name reserve and release
        repeat (3) applyStimulus(0, 1, 7, 0, 0, 0, 7, 7);
        applyStimulus(0, 1, 7, 1, 7, 0, 7, 7);
        applyStimulus(0, 1, 7, 0, 0, 0, 7, 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        // flush beats a same-cycle reserve
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 2);
        applyStimulus(0, 1, 2, 0, 0, 0, 1, 2);
        applyStimulus(0, 1, 4, 0, 0, 0, 4, 9);
        applyStimulus(0, 1, 9, 0, 0, 1, 1, 2);
        applyStimulus(0, 0, 9, 0, 0, 0, 4, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);
        // last release of r6 seen by the rs query
        applyStimulus(0, 1, 6, 0, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 1, 6, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 6);
        // release of an idle register
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Names are biased to a few registers so counters reach saturation often.
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 49) == 0);
            rsv  = ($urandom_range(0, 1) == 1);
            rel  = ($urandom_range(0, 2) == 0);
            rsn  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 3);
            reln = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 3);
            rdq  = ($urandom_range(0, 1) == 1) ? reln : $urandom_range(0, NREG - 1);
            rsq  = ($urandom_range(0, 1) == 1) ? rsn : $urandom_range(0, NREG - 1);
            if (fl) begin
                rsv = 1'b0;
                rel = 1'b0;
            end
            if (rsv && rel && rsn == reln && cnt_m[rsn] == 0) rel = 1'b0;
            applyStimulus(r, rsv, rsn, rel, reln, fl, rdq, rsq);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #4;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 16: number of architectural registers; must be a power of two.
REQ-002 SHALL have parameter W_NAME, default 4: register-name width, equal to log2(NREG).
REQ-003 SHALL have parameter CNT_W, default 2: per-register pending-write counter width; maximum in-flight writes per register is 2^CNT_W-1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rd_name_i  input  W_NAME  decode-stage rd register name to query.
REQ-008 rs_name_i  input  W_NAME  decode-stage rs register name to query.
REQ-009 rd_reserved_o  output  1  rd_name_i has a pending write.
REQ-010 rs_reserved_o  output  1  rs_name_i has a pending write.
REQ-011 reserve_i  input  1  issue of a write-back instruction; reserves reserve_name_i.
REQ-012 reserve_name_i  input  W_NAME  register being reserved.
REQ-013 release_i  input  1  write-back completed; releases release_name_i.
REQ-014 release_name_i  input  W_NAME  register being released.
REQ-015 flush_i  input  1  discard all pending reservations.
REQ-016 full_o  output  1  counter of reserve_name_i is at maximum; issue must stall.
REQ-017 idle_o  output  1  all counters are zero.
REQ-018 err_o  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL hold one CNT_W-bit counter per register; a register is reserved iff its counter is nonzero.
REQ-020 A reserve_i accepted at cycle N SHALL increment the counter for reserve_name_i, visible on the query outputs in cycle N+1.
REQ-021 A release_i at cycle N SHALL decrement the counter for release_name_i in cycle N+1.
REQ-022 Simultaneous reserve and release of the same name SHALL leave that counter unchanged; for different names, both updates SHALL apply.
REQ-023 A reserve_i while full_o=1 SHALL be ignored, and err_o SHALL be set.
REQ-024 A release_i of a name whose counter is zero SHALL be ignored, and err_o SHALL be set.
REQ-025 A reserve_i at maximum with a same-cycle same-name release SHALL be legal and SHALL leave the counter unchanged, with no error.
REQ-026 flush_i SHALL zero all counters in the next cycle and SHALL take priority over reserve_i and release_i in the same cycle; err_o SHALL be unaffected.
REQ-027 full_o SHALL be combinational from the state and reserve_name_i; the same-cycle release exception of REQ-025 SHALL NOT lower it.
REQ-028 idle_o SHALL be the registered-state NOR of all counters.
REQ-029 rd_reserved_o and rs_reserved_o SHALL be combinational from the state and the name inputs only (except as in REQ-033); a same-cycle reserve SHALL NOT affect them.
REQ-030 err_o, once set, SHALL remain 1 until rst.

Reset
REQ-031 rst=1 at a clock edge SHALL zero all counters and err_o, overriding all other inputs, including mid-operation.
REQ-032 After reset: rd_reserved_o=0, rs_reserved_o=0, full_o=0, idle_o=1, err_o=0.

Configuration
REQ-033 With macro SCB_WB_BYPASS_EN defined, a query output SHALL read 0 when release_i names the queried register and its counter equals 1 (same-cycle write-back forwarding); without the macro, query outputs SHALL reflect the registered state only.

Verification
REQ-034 After reset, reserve r3 at cycle 0; query rd=3 at cycle 1 -> rd_reserved_o=1, idle_o=0; release r3 at cycle 1 -> at cycle 2 rd_reserved_o=0, idle_o=1.
REQ-035 With CNT_W=2, reserve r5 three times -> full_o=1 for name 5; a fourth reserve -> counter stays 3 and err_o=1 until rst.
REQ-036 Counter of r7=3; reserve and release r7 in the same cycle -> counter stays 3 and err_o stays 0.
REQ-037 Reserve r1, r2, r4; then flush_i plus reserve r9 in the same cycle -> next cycle all queries are 0 and idle_o=1.
REQ-038 Counter of r6=1; release r6 while querying rs=6: with SCB_WB_BYPASS_EN defined -> rs_reserved_o=0 that cycle; without it -> 1 that cycle and 0 the next.
REQ-039 Release r0 with its counter at 0 -> err_o=1 and counters unchanged; assert rst -> err_o=0.
